// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package ssd_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_FONT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
  } disp_data_t;

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to active-low segment decoder using the shared font.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_FONT[nibble_i];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode scan controller with double-buffered display data.
// state | meaning
// BLANK | all anodes off for BLANK_TICKS cycles before digit idx
// SHOW  | digit idx lit for DIGIT_TICKS cycles
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  digit_en_i,
  input  logic        load_i,
  output logic        pending_o,
  output logic        frame_start_o,
  output logic        SSD_CA,
  output logic        SSD_CB,
  output logic        SSD_CC,
  output logic        SSD_CD,
  output logic        SSD_CE,
  output logic        SSD_CF,
  output logic        SSD_CG,
  output logic        SSD_DP,
  output logic        SSD_AN0,
  output logic        SSD_AN1,
  output logic        SSD_AN2,
  output logic        SSD_AN3
);

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS)
                           ? ((DIGIT_TICKS > 2) ? DIGIT_TICKS : 2)
                           : ((BLANK_TICKS > 2) ? BLANK_TICKS : 2);
  localparam int CW = $clog2(MAX_TICKS);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_TICKS == 0) ? 0 : BLANK_TICKS - 1);

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  disp_data_t    shadow_q, shadow_d;
  disp_data_t    display_q, display_d;
  logic          pending_q, pending_d;
  logic          frame_start_q, frame_start_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          wrap;
  logic          cnt_last;
  logic [6:0]    dec_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      display_q     <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      an_q          <= 4'hF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      display_q     <= display_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    wrap      = 1'b0;
    if (state_q == BLANK) begin
      cnt_last = (BLANK_TICKS == 0) || (cnt_q == BLANK_LAST);
    end else begin
      cnt_last = (cnt_q == DIGIT_LAST);
    end
    if (cnt_last) begin
      cnt_d = '0;
      if (state_q == BLANK) begin
        state_d = SHOW;
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = (BLANK_TICKS == 0) ? SHOW : BLANK;
        wrap    = (idx_q == IW'(NUM_DIGITS - 1));
      end
    end

    // The boundary copy uses the old shadow, so a load on this edge stays pending.
    display_d = (wrap && pending_q) ? shadow_q : display_q;
    shadow_d  = load_i ? '{value: value_i, dp: dp_i, en: digit_en_i} : shadow_q;
    pending_d = load_i ? 1'b1 : ((wrap && pending_q) ? 1'b0 : pending_q);
  end

  ssd_hex_decode u_dec (
    .nibble_i (display_d.value[{idx_d, 2'b00} +: 4]),
    .seg_o    (dec_seg)
  );

  // Pin values are computed from the next state so they change on the same edge.
  always_comb begin
    frame_start_d = wrap && pending_q;
    an_d          = 4'hF;
    seg_d         = SEG_BLANK;
    dp_d          = 1'b1;
    if (state_d == SHOW && display_d.en[idx_d]) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = dec_seg;
      dp_d  = ~display_d.dp[idx_d];
    end
  end

  assign pending_o     = pending_q;
  assign frame_start_o = frame_start_q;
  assign {SSD_CG, SSD_CF, SSD_CE, SSD_CD, SSD_CC, SSD_CB, SSD_CA} = seg_q;
  assign SSD_DP = dp_q;
  assign {SSD_AN3, SSD_AN2, SSD_AN1, SSD_AN0} = an_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench: directed scenarios plus random loads/resets against a frame-position model.
module tb_ssd_scan_ctrl;

  localparam int DT    = 4;
  localparam int BT    = 2;
  localparam int SLOT  = DT + BT;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  digit_en_i = '0;
  logic        load_i = 1'b0;
  logic        pending_o, frame_start_o;
  logic        SSD_CA, SSD_CB, SSD_CC, SSD_CD, SSD_CE, SSD_CF, SSD_CG, SSD_DP;
  logic        SSD_AN0, SSD_AN1, SSD_AN2, SSD_AN3;

  ssd_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
    .clk           (clk),
    .rst           (rst),
    .value_i       (value_i),
    .dp_i          (dp_i),
    .digit_en_i    (digit_en_i),
    .load_i        (load_i),
    .pending_o     (pending_o),
    .frame_start_o (frame_start_o),
    .SSD_CA        (SSD_CA),
    .SSD_CB        (SSD_CB),
    .SSD_CC        (SSD_CC),
    .SSD_CD        (SSD_CD),
    .SSD_CE        (SSD_CE),
    .SSD_CF        (SSD_CF),
    .SSD_CG        (SSD_CG),
    .SSD_DP        (SSD_DP),
    .SSD_AN0       (SSD_AN0),
    .SSD_AN1       (SSD_AN1),
    .SSD_AN2       (SSD_AN2),
    .SSD_AN3       (SSD_AN3)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: t counts edges since the last reset edge; the frame position follows from t.
  int          t;
  logic [15:0] m_val, s_val;
  logic [3:0]  m_dp, m_en, s_dp, s_en;
  logic        m_pend, m_fs;

  logic [3:0] ever_low;
  logic [6:0] seg_pins;
  logic [3:0] an_pins;

  assign seg_pins = {SSD_CG, SSD_CF, SSD_CE, SSD_CD, SSD_CC, SSD_CB, SSD_CA};
  assign an_pins  = {SSD_AN3, SSD_AN2, SSD_AN1, SSD_AN0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
    end
  endtask

  function automatic logic [6:0] font(input logic [3:0] n);
    string      lit;
    logic [6:0] r;
    case (n)
      4'h0: lit = "abcdef";   4'h1: lit = "bc";
      4'h2: lit = "abdeg";    4'h3: lit = "abcdg";
      4'h4: lit = "bcfg";     4'h5: lit = "acdfg";
      4'h6: lit = "acdefg";   4'h7: lit = "abc";
      4'h8: lit = "abcdefg";  4'h9: lit = "abcdfg";
      4'hA: lit = "abcefg";   4'hB: lit = "cdefg";
      4'hC: lit = "adef";     4'hD: lit = "bcdeg";
      4'hE: lit = "adefg";    default: lit = "aefg";
    endcase
    r = 7'h7F;
    for (int i = 0; i < lit.len(); i++) r[lit[i] - 8'd97] = 1'b0;
    return r;
  endfunction

  function automatic logic [11:0] pins_exp();
    int         pos, d, ph;
    logic [3:0] an;
    pos = t % FRAME;
    d   = pos / SLOT;
    ph  = pos % SLOT;
    if (ph >= BT && m_en[d]) begin
      an    = 4'hF;
      an[d] = 1'b0;
      return {an, ~m_dp[d], font(m_val[d*4 +: 4])};
    end
    return 12'hFFF;
  endfunction

  task automatic check_all();
    chk("pins", {an_pins, SSD_DP, seg_pins}, pins_exp());
    chk("pending", pending_o, m_pend);
    chk("frame_start", frame_start_o, m_fs);
    chk("an_onehot", ($countones(~an_pins) <= 1), 1);
    ever_low |= ~an_pins;
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    load_i     = ld;
    value_i    = v;
    dp_i       = d;
    digit_en_i = e;
    @(posedge clk);
    t++;
    m_fs = 1'b0;
    if (t % FRAME == 0 && m_pend) begin
      m_val  = s_val;
      m_dp   = s_dp;
      m_en   = s_en;
      m_pend = 1'b0;
      m_fs   = 1'b1;
    end
    if (ld) begin
      s_val  = v;
      s_dp   = d;
      s_en   = e;
      m_pend = 1'b1;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    load_i = 1'b0;
    @(posedge clk);
    t = 0;
    {m_val, m_dp, m_en, s_val, s_dp, s_en} = '0;
    m_pend = 1'b0;
    m_fs   = 1'b0;
    #1;
    check_all();
    chk("reset_pins", {an_pins, SSD_DP, seg_pins}, 12'hFFF);
    rst = 1'b0;
  endtask

  initial begin
    t = 0;
    ever_low = '0;

    // Idle after reset: fully dark, no pulse.
    do_reset();
    idle(100);

    // Single load at cycle 5, visible from the first frame boundary.
    do_reset();
    idle(5);
    step(1'b1, 16'h1234, 4'b0001, 4'hF);
    chk("pend_after_load", pending_o, 1'b1);
    while (t < 24) idle(1);
    chk("fs_at_24", frame_start_o, 1'b1);
    while (t < 26) idle(1);
    chk("an0_at_26", SSD_AN0, 1'b0);
    chk("seg_4_at_26", seg_pins, 7'h19);
    chk("dp0_at_26", SSD_DP, 1'b0);
    chk("pend_at_26", pending_o, 1'b0);
    while (t < 32) idle(1);
    chk("an1_at_32", SSD_AN1, 1'b0);
    chk("seg_3_at_32", seg_pins, 7'h30);
    idle(30);

    // Partial enable: only AN0/AN2 ever light.
    do_reset();
    step(1'b1, 16'hFFFF, 4'b0000, 4'b0101);
    ever_low = '0;
    idle(3 * FRAME);
    chk("en_mask_lit", ever_low, 4'b0101);

    // Two loads then a load on the boundary edge.
    do_reset();
    while (t < 60) begin
      if (t == 10)      step(1'b1, 16'hAAAA, 4'h0, 4'hF);
      else if (t == 12) step(1'b1, 16'h5555, 4'h0, 4'hF);
      else if (t == 23) step(1'b1, 16'h0000, 4'h0, 4'hF);
      else              idle(1);
      if (t == 24) chk("pend_kept_at_24", pending_o, 1'b1);
      if (t == 27) chk("seg_5_at_27", seg_pins, 7'h12);
      if (t == 51) chk("seg_0_at_51", seg_pins, 7'h40);
    end

    // Reset during SHOW(2) while 8888 is displayed.
    do_reset();
    step(1'b1, 16'h8888, 4'hF, 4'hF);
    while (t < 39) idle(1);
    chk("an2_before_rst", SSD_AN2, 1'b0);
    do_reset();
    idle(30);

    // Random loads and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else step(r < 12, 16'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display.
- Takes a 16-bit hex value plus per-digit enable and decimal-point masks, and double-buffers them.
- Cycles the four anodes with a blanking gap between digits to suppress ghosting.
- Drives active-low segment and anode pins directly; replaces the static "digit 0 only" display hookup.

Parameters:
- DIGIT_TICKS, 50000: clk cycles a digit is lit per visit (must be >= 1); 0.5 ms at 100 MHz.
- BLANK_TICKS, 500: clk cycles all anodes are off before each digit (0 = no blank phase).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- value_i  in  16  hex nibbles; [3:0] shows on digit 0 (AN0), [15:12] on digit 3 (AN3)
- dp_i  in  4  decimal point per digit, 1 = lit
- digit_en_i  in  4  per-digit enable, 1 = digit shown, 0 = digit dark
- load_i  in  1  single-cycle strobe; captures value_i/dp_i/digit_en_i into the shadow register
- pending_o  out  1  shadow holds data not yet shown
- frame_start_o  out  1  one-cycle pulse when shadow is copied to the display register
- SSD_CA..SSD_CG  out  1 each  segments a..g, active-low
- SSD_DP  out  1  decimal point, active-low
- SSD_AN0..SSD_AN3  out  1 each  digit anodes, active-low

Behaviour:
- Reset values:
  - All SSD_* outputs = 1 (everything dark).
  - pending_o = 0, frame_start_o = 0.
  - Shadow and display registers = 0, so digit_en = 0 and the display stays dark until the first load.
  - State = BLANK, idx = 0, tick counter = 0.
- State machine, two states:
  - BLANK: lasts BLANK_TICKS cycles; skipped when BLANK_TICKS = 0.
  - SHOW: lasts DIGIT_TICKS cycles.
  - Order: BLANK(idx) -> SHOW(idx) -> BLANK(idx+1 mod 4). The tick counter restarts at 0 on every state change.
- Frame boundary = the edge where idx wraps 3 -> 0, plus the first BLANK(0) after reset.
  - If pending_o = 1 at this boundary: display <= shadow, pending_o <= 0, frame_start_o = 1 for exactly one cycle.
  - If pending_o = 0: no copy and no pulse.
- Load handling:
  - load_i = 1 on any edge: shadow <= inputs, pending_o <= 1.
  - Repeated loads before the boundary: last one wins.
  - load_i on the boundary edge itself: the display takes the old shadow; the shadow takes the new inputs; pending_o stays 1; frame_start_o still pulses.
- Output rules:
  - Outputs are registered and take their new values on the same edge that the state/idx changes. No combinational path reaches the pins.
  - In BLANK: all anodes = 1, all segments = 1, SSD_DP = 1.
  - In SHOW(idx): SSD_ANidx = ~display_en[idx] and all other anodes = 1. Segments = decode(display nibble idx); SSD_DP = ~display_dp[idx].
  - If display_en[idx] = 0, segments and DP are also forced to 1.
- Hex decode, active-low, a..g:
  - 0 -> only g off.
  - 8 -> all on.
  - 4 -> b, c, f, g on.
  - F -> a, e, f, g on.
  - Full 0-F hex font: A, b, C, d, E, F.
- Timing:
  - Frame period = 4*(BLANK_TICKS + DIGIT_TICKS) cycles.
  - A load becomes visible within at most one frame plus BLANK_TICKS cycles.
- rst mid-frame: immediate return to the reset state; shadow data and any pending load are discarded.
- Counter width: $clog2 of max(DIGIT_TICKS, BLANK_TICKS, 2). Terminal compare is at TICKS-1; no counter overflow is possible.

Decomposition:
- Shared package ssd_pkg:
  - 7-bit active-low segment constants SEG_BLANK = 7'h7F and the 16-entry hex font.
  - Scan state enum {BLANK, SHOW}.
  - Digit count constant NUM_DIGITS = 4.
- One sub-module, ssd_hex_decode: combinational 4-bit nibble -> 7-bit active-low segments, using the package font.
- Shadow/display registers, FSM, counter and output registers stay in ssd_scan_ctrl.

Test Plan (DIGIT_TICKS=4, BLANK_TICKS=2, frame = 24 cycles):
- Reset, no load -> all SSD_* = 1 for 100 cycles; pending_o = 0; frame_start_o never pulses.
- Release rst at cycle 0; load_i at cycle 5 with value_i=16'h1234, digit_en_i=4'hF, dp_i=4'b0001:
  - pending_o = 1 from cycle 6.
  - frame_start_o pulses at cycle 24; pending_o = 0 after it.
  - Cycles 26-29: SSD_AN0 = 0, segments show "4" (CB, CC, CF, CG = 0; CA, CD, CE = 1); SSD_DP = 0.
  - Cycles 32-35: SSD_AN1 = 0, segments show "3".
- Anode check over one full frame: never more than one anode low; all anodes high in every BLANK window.
- digit_en_i=4'b0101 with value 16'hFFFF -> only AN0 and AN2 ever go low, each showing "F" (CA, CE, CF, CG = 0). AN1 and AN3 slots stay fully dark.
- Two loads (16'hAAAA at cycle 10, 16'h5555 at cycle 12), plus a third load (16'h0000) coinciding with the boundary edge:
  - The boundary copy displays 16'h5555.
  - The 16'h0000 load keeps pending_o = 1 and shows from the next frame.
- Assert rst during SHOW(2), displaying 16'h8888 -> next edge all SSD_* = 1 and pending_o = 0. After release the display stays dark, since the display register is 0.
